// File: rtl/multiplier_sequential_n_bit.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with unsigned and
// two's-complement modes. Busy/done are registered views of the FSM state.
module multiplier_sequential_n_bit #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      Clock_In,
    input  logic                      Reset_In,
    input  logic                      Start_In,
    input  logic                      Signed_Mode_In,
    input  logic [DATA_WIDTH-1:0]     Data_A_In,
    input  logic [DATA_WIDTH-1:0]     Data_B_In,
    output logic                      Busy_Out,
    output logic                      Done_Out,
    output logic [2*DATA_WIDTH-1:0]   Multiplied_Result_Out
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [PW-1:0]        a_reg;
    logic [PW-1:0]        acc;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [CW-1:0]        count;
    logic                 signed_reg;

    logic [PW-1:0]        addend;
    logic [PW-1:0]        acc_next;

    // In signed mode the multiplier MSB carries negative weight, so its partial product is subtracted.
    always_comb begin
        addend   = '0;
        acc_next = acc;
        if (b_reg[0]) begin
            addend = a_reg;
        end
        if (signed_reg && (count == LAST)) begin
            acc_next = acc - addend;
        end else begin
            acc_next = acc + addend;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state                 <= IDLE;
            a_reg                 <= '0;
            b_reg                 <= '0;
            acc                   <= '0;
            count                 <= '0;
            signed_reg            <= 1'b0;
            Busy_Out              <= 1'b0;
            Done_Out              <= 1'b0;
            Multiplied_Result_Out <= '0;
        end else begin
            Busy_Out <= (state == CALC);
            Done_Out <= (state == DONE);
            case (state)
                IDLE: begin
                    if (Start_In) begin
                        // Multiplicand is pre-extended to full product width so shifts stay exact.
                        if (Signed_Mode_In) begin
                            a_reg <= {{DATA_WIDTH{Data_A_In[DATA_WIDTH-1]}}, Data_A_In};
                        end else begin
                            a_reg <= {{DATA_WIDTH{1'b0}}, Data_A_In};
                        end
                        b_reg      <= Data_B_In;
                        signed_reg <= Signed_Mode_In;
                        acc        <= '0;
                        count      <= '0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        Multiplied_Result_Out <= acc_next;
                        state                 <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/multiplier_sequential_n_bit.md
MULTIPLIER_SEQUENTIAL_N_BIT -- requirements
Module: Multiplier_Sequential_N_Bit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port Clock_In  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_In  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port Start_In  input  1  request to begin a multiplication.
REQ-005 SHALL have port Signed_Mode_In  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port Data_A_In  input  DATA_WIDTH  multiplicand.
REQ-007 SHALL have port Data_B_In  input  DATA_WIDTH  multiplier.
REQ-008 SHALL have port Busy_Out  output  1  high while a multiplication is in progress.
REQ-009 SHALL have port Done_Out  output  1  one-cycle pulse marking a valid new result.
REQ-010 SHALL have port Multiplied_Result_Out  output  2*DATA_WIDTH  registered product.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-012 IDLE with Start_In=1 at an edge: SHALL capture Data_A_In, Data_B_In and Signed_Mode_In, clear the iteration counter, and go to CALC.
REQ-013 IDLE with Start_In=0: SHALL stay in IDLE.
REQ-014 CALC SHALL process one multiplier bit per clock (shift-add) for exactly DATA_WIDTH edges, then go to DONE.
REQ-015 On the edge entering DONE, SHALL load the final product into Multiplied_Result_Out.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: with the start edge as edge 0, Done_Out SHALL be high in the cycle after edge DATA_WIDTH+1 and the result SHALL be valid from that edge.
REQ-018 Busy_Out SHALL be 1 in CALC and 0 in IDLE and DONE; Done_Out SHALL be 1 only in DONE; both SHALL be registered outputs.
REQ-019 Start_In SHALL be ignored in CALC and DONE; no queuing of requests.
REQ-020 Changes on Data_A_In, Data_B_In or Signed_Mode_In after the start edge SHALL NOT affect the operation in progress.
REQ-021 With Start_In held high continuously, SHALL start a new operation on every IDLE edge, giving one result per DATA_WIDTH+2 cycles.
REQ-022 Unsigned mode: result SHALL equal A*B zero-extended to exactly 2*DATA_WIDTH bits, with no overflow.
REQ-023 Signed mode: result SHALL equal the two's-complement product in 2*DATA_WIDTH bits.
REQ-024 The signed corner case (-2^(W-1))*(-2^(W-1)) SHALL produce +2^(2W-2) exactly.
REQ-025 Multiplied_Result_Out SHALL hold its value between completions and change only on the edge entering DONE.
REQ-026 A zero operand SHALL still take the full latency; no early termination.

Reset
REQ-027 Reset_In low SHALL immediately force state IDLE, Busy_Out=0, Done_Out=0, Multiplied_Result_Out=0, and clear the counter and operand registers, regardless of the clock.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation; no Done_Out pulse and no partial result SHALL appear.
REQ-029 After Reset_In deasserts, the first Start_In=1 edge SHALL be accepted normally.

Verification (DATA_WIDTH=8 unless noted)
REQ-030 Unsigned: A=0xFF, B=0xFF, Signed=0, Start pulse at edge 0 -> Busy high for 8 cycles, Done pulse after edge 9, result 0xFE01.
REQ-031 Signed/unsigned pair: A=0xFF, B=0x02 -> Signed=1 gives 0xFFFE; Signed=0 gives 0x01FE. Signed corner A=0x80, B=0x80, Signed=1 -> 0x4000.
REQ-032 Operand and start isolation: start with A=3, B=5, then drive A=0xAA, B=0x55, Signed=1 and hold Start high during CALC -> result 0x000F, and exactly one Done pulse for that operation.
REQ-033 Reset abort: start 0x12*0x34, pull Reset_In low at cycle 4 -> all outputs 0 at once, no Done pulse; after release, a new 0x12*0x34 -> 0x03A8.
REQ-034 Back-to-back: hold Start high with fixed A=7, B=9 -> a Done pulse every 10 cycles, each with 0x003F; result stable between pulses.
REQ-035 Random: 500 random operands and modes at DATA_WIDTH=8 and DATA_WIDTH=13, checked against a behavioural model -> zero mismatches.
